// File: rtl/bcd_updown_counter.sv
// NDIG-digit BCD up/down counter with parallel load, wrap pulse, zero detect and load validation.
// Optional build macro BCD_SAT_EN: saturate at the limits, with wrap reporting blocked steps.
module bcd_updown_counter #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] count,
    output logic              wrap,
    output logic              zero,
    output logic              load_err
);

    logic [4*NDIG-1:0] count_r;
    logic              wrap_r;
    logic              load_err_r;

    logic [4*NDIG-1:0] step_s;
    logic [NDIG:0]     carry_s;
    logic              limit_s;
    logic [4*NDIG-1:0] load_fix_s;
    logic              load_bad_s;
    logic [4*NDIG-1:0] count_nxt_s;
    logic              wrap_nxt_s;
    logic              load_err_nxt_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // One BCD step: carry/borrow ripples from digit 0; a carry out of the top digit is a wrap.
    always_comb begin
        step_s     = count_r;
        carry_s    = '0;
        carry_s[0] = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry_s[i]) begin
                if (dir) begin
                    if (count_r[4*i +: 4] == 4'd9) begin
                        step_s[4*i +: 4] = 4'd0;
                        carry_s[i+1]     = 1'b1;
                    end else begin
                        step_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
                        carry_s[i+1]     = 1'b0;
                    end
                end else begin
                    if (count_r[4*i +: 4] == 4'd0) begin
                        step_s[4*i +: 4] = 4'd9;
                        carry_s[i+1]     = 1'b1;
                    end else begin
                        step_s[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
                        carry_s[i+1]     = 1'b0;
                    end
                end
            end else begin
                step_s[4*i +: 4] = count_r[4*i +: 4];
                carry_s[i+1]     = 1'b0;
            end
        end
        limit_s = carry_s[NDIG];
    end

    // Load sanitising: out-of-range digits become 9 and are flagged.
    always_comb begin
        load_fix_s = '0;
        load_bad_s = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            load_fix_s[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
            load_bad_s           = load_bad_s | digit_invalid(load_val[4*i +: 4]);
        end
    end

    // Next-state selection with load taking priority over counting.
    always_comb begin
        count_nxt_s    = count_r;
        wrap_nxt_s     = 1'b0;
        load_err_nxt_s = 1'b0;
        if (load) begin
            count_nxt_s    = load_fix_s;
            load_err_nxt_s = load_bad_s;
        end else if (en) begin
`ifdef BCD_SAT_EN
            if (limit_s) begin
                count_nxt_s = count_r;
                wrap_nxt_s  = 1'b1;
            end else begin
                count_nxt_s = step_s;
                wrap_nxt_s  = 1'b0;
            end
`else
            count_nxt_s = step_s;
            wrap_nxt_s  = limit_s;
`endif
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r    <= '0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            wrap_r     <= wrap_nxt_s;
            load_err_r <= load_err_nxt_s;
        end
    end

    assign count    = count_r;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;
    assign zero     = ~|count_r;

endmodule
